// File: rtl/centroid_accumulator_pkg.sv
// Shared sizes, types and state encoding for the k-means centroid accumulator.
// Imported by the interface, the sequential divider and the top.
package centroid_accumulator_pkg;

  localparam int N_CORES = 16;
  localparam int IDX_W   = 4;
  localparam int COORD_W = 8;
  localparam int CNT_W   = 12;
  localparam int SUM_W   = COORD_W + CNT_W;
  localparam int STEP_W  = 5;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [SUM_W-1:0]   sum_t;
  typedef logic [STEP_W-1:0]  step_t;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DIV   = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  localparam idx_t  LAST_IDX  = idx_t'(N_CORES - 1);
  localparam cnt_t  CNT_ONE   = cnt_t'(1);
  localparam step_t STEP_ONE  = step_t'(1);
  localparam step_t STEP_LAST = step_t'(SUM_W);

  function automatic sum_t widen_coord(input coord_t c);
    return {{(SUM_W - COORD_W){1'b0}}, c};
  endfunction

  // A saturated counter refuses further members for the rest of the epoch.
  function automatic logic cnt_full(input cnt_t c);
    return &c;
  endfunction

endpackage

// File: rtl/centroid_accumulator_if.sv
// Point-in / centroid-out bundle of the accumulator, with the upstream/consumer
// side as master and the accumulator itself as slave.
interface centroid_accumulator_if;
  import centroid_accumulator_pkg::*;

  logic   pt_valid;
  logic   pt_ready;
  coord_t pt_x;
  coord_t pt_y;
  idx_t   pt_core;
  logic   epoch_done;
  logic   cen_valid;
  logic   cen_ready;
  idx_t   cen_idx;
  coord_t cen_x;
  coord_t cen_y;
  logic   cen_empty;
  logic   busy;
  logic   acc_ovf;

  modport master (
    output pt_valid, pt_x, pt_y, pt_core, epoch_done, cen_ready,
    input  pt_ready, cen_valid, cen_idx, cen_x, cen_y, cen_empty, busy, acc_ovf
  );

  modport slave (
    input  pt_valid, pt_x, pt_y, pt_core, epoch_done, cen_ready,
    output pt_ready, cen_valid, cen_idx, cen_x, cen_y, cen_empty, busy, acc_ovf
  );

endinterface

// File: rtl/centroid_accumulator_seq_divider.sv
// Restoring divider, one quotient bit per cycle. done pulses exactly SUM_W+1
// cycles after the start cycle; only the low COORD_W quotient bits leave.
module seq_divider
  import centroid_accumulator_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  sum_t   dividend,
  input  cnt_t   divisor,
  output logic   done,
  output coord_t quotient
);

  sum_t  quo_q, quo_d;
  cnt_t  rem_q, rem_d;
  cnt_t  dvs_q, dvs_d;
  step_t step_q, step_d;
  logic  run_q, run_d;
  logic  done_q, done_d;

  logic [CNT_W:0] shift_s;
  logic [CNT_W:0] diff_s;

  // One restoring step per cycle; the borrow bit of diff_s decides restore.
  always_comb begin
    shift_s = {rem_q, quo_q[SUM_W-1]};
    diff_s  = shift_s - {1'b0, dvs_q};
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    step_d  = step_q;
    run_d   = run_q;
    done_d  = 1'b0;
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      step_d = STEP_LAST;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (diff_s[CNT_W]) begin
        rem_d = shift_s[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end else begin
        rem_d = diff_s[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end
      step_d = step_q - STEP_ONE;
      if (step_q == STEP_ONE) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      step_q <= step_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q[COORD_W-1:0];

endmodule

// File: rtl/centroid_accumulator.sv
// K-means update stage: accumulates tagged points per core, then on epoch end
// divides sums by counts and streams the N_CORES new centroids in index order.
module centroid_accumulator
  import centroid_accumulator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  centroid_accumulator_if.slave bus
);

  logic   rst_meta_q, rst_sync_q;
  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  logic   wait_q, wait_d;
  logic   cen_valid_q, cen_valid_d;
  idx_t   cen_idx_q, cen_idx_d;
  coord_t cen_x_q, cen_x_d;
  coord_t cen_y_q, cen_y_d;
  logic   cen_empty_q, cen_empty_d;
  logic   ovf_q, ovf_d;
  sum_t   sum_x_q [N_CORES];
  sum_t   sum_x_d [N_CORES];
  sum_t   sum_y_q [N_CORES];
  sum_t   sum_y_d [N_CORES];
  cnt_t   cnt_q   [N_CORES];
  cnt_t   cnt_d   [N_CORES];

  logic   div_start_s;
  logic   done_x_s, done_y_s;
  coord_t quo_x_s, quo_y_s;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  seq_divider u_div_x (
    .clk      (clk),
    .rst_n    (rst_sync_q),
    .start    (div_start_s),
    .dividend (sum_x_q[idx_q]),
    .divisor  (cnt_q[idx_q]),
    .done     (done_x_s),
    .quotient (quo_x_s)
  );

  seq_divider u_div_y (
    .clk      (clk),
    .rst_n    (rst_sync_q),
    .start    (div_start_s),
    .dividend (sum_y_q[idx_q]),
    .divisor  (cnt_q[idx_q]),
    .done     (done_y_s),
    .quotient (quo_y_s)
  );

  // Next-state logic for the FSM, accumulators and registered centroid outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    cen_valid_d = cen_valid_q;
    cen_idx_d   = cen_idx_q;
    cen_x_d     = cen_x_q;
    cen_y_d     = cen_y_q;
    cen_empty_d = cen_empty_q;
    ovf_d       = ovf_q;
    sum_x_d     = sum_x_q;
    sum_y_d     = sum_y_q;
    cnt_d       = cnt_q;
    div_start_s = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (bus.pt_valid) begin
          if (cnt_full(cnt_q[bus.pt_core])) begin
            ovf_d = 1'b1;
          end else begin
            sum_x_d[bus.pt_core] = sum_x_q[bus.pt_core] + widen_coord(bus.pt_x);
            sum_y_d[bus.pt_core] = sum_y_q[bus.pt_core] + widen_coord(bus.pt_y);
            cnt_d[bus.pt_core]   = cnt_q[bus.pt_core] + CNT_ONE;
          end
        end else begin
          ovf_d = ovf_q;
        end
        if (bus.epoch_done) begin
          state_d = ST_DIV;
          idx_d   = '0;
          wait_d  = 1'b0;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DIV: begin
        if (!wait_q) begin
          if (cnt_q[idx_q] == '0) begin
            cen_valid_d = 1'b1;
            cen_idx_d   = idx_q;
            cen_x_d     = '0;
            cen_y_d     = '0;
            cen_empty_d = 1'b1;
            state_d     = ST_EMIT;
          end else begin
            div_start_s = 1'b1;
            wait_d      = 1'b1;
          end
        end else if (done_x_s && done_y_s) begin
          wait_d      = 1'b0;
          cen_valid_d = 1'b1;
          cen_idx_d   = idx_q;
          cen_x_d     = quo_x_s;
          cen_y_d     = quo_y_s;
          cen_empty_d = 1'b0;
          state_d     = ST_EMIT;
        end else begin
          wait_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (bus.cen_ready) begin
          sum_x_d[idx_q] = '0;
          sum_y_d[idx_q] = '0;
          cnt_d[idx_q]   = '0;
          cen_valid_d    = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_ACCUM;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_DIV;
          end
        end else begin
          cen_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_ACCUM;
        cen_valid_d = 1'b0;
        wait_d      = 1'b0;
      end
    endcase
  end

  // FSM, per-core accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= ST_ACCUM;
      idx_q       <= '0;
      wait_q      <= 1'b0;
      cen_valid_q <= 1'b0;
      cen_idx_q   <= '0;
      cen_x_q     <= '0;
      cen_y_q     <= '0;
      cen_empty_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        sum_x_q[i] <= '0;
        sum_y_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      cen_valid_q <= cen_valid_d;
      cen_idx_q   <= cen_idx_d;
      cen_x_q     <= cen_x_d;
      cen_y_q     <= cen_y_d;
      cen_empty_q <= cen_empty_d;
      ovf_q       <= ovf_d;
      sum_x_q     <= sum_x_d;
      sum_y_q     <= sum_y_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.pt_ready  = (state_q == ST_ACCUM);
  assign bus.busy      = (state_q != ST_ACCUM);
  assign bus.cen_valid = cen_valid_q;
  assign bus.cen_idx   = cen_idx_q;
  assign bus.cen_x     = cen_x_q;
  assign bus.cen_y     = cen_y_q;
  assign bus.cen_empty = cen_empty_q;
  assign bus.acc_ovf   = ovf_q;

endmodule
